// File: rtl/gat_feat_readback.sv
`default_nettype none
// ============================================================================
// Module      : gat_feat_readback
// Description : Sweeps a word range of the new-feature BRAM and streams it out
//               on valid/ready/last, with a credit-limited output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module gat_feat_readback #(
    parameter int NEW_FEATURE_WIDTH  = 32,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [NEW_FEATURE_ADDR_W-1:0]   rd_base,
    input  logic [NEW_FEATURE_ADDR_W:0]     rd_len,
    output logic                            busy,
    output logic                            done,
    output logic                            range_err,
    output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
    output logic                            feat_bram_enb,
    input  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]    m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast
);

    localparam int c_aw    = NEW_FEATURE_ADDR_W;
    localparam int c_lw    = NEW_FEATURE_ADDR_W + 1;
    localparam int c_ew    = NEW_FEATURE_ADDR_W + 2;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_ew-1:0]    c_depth_ext  = c_ew'(NEW_FEATURE_DEPTH);
    localparam logic [c_cnt_w-1:0] c_credit_max = c_cnt_w'(FIFO_DEPTH - 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_ISSUE  = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [c_aw-1:0]            word_idx_q, word_idx_d;
    logic [c_lw-1:0]            len_q, len_d;
    logic [c_lw-1:0]            issued_q, issued_d;
    logic [c_lw-1:0]            sent_q, sent_d;
    logic                       range_err_q, range_err_d;
    logic [c_ew-1:0]            addrb_q, addrb_d;
    logic                       inflight_q;
    logic [c_cnt_w-1:0]         count_q, count_d;
    logic [c_ptr_w-1:0]         wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]         rd_ptr_q, rd_ptr_d;
    logic [NEW_FEATURE_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                       w_issue;
    logic                       w_credit_ok;
    logic [c_ew-1:0]            w_end;
    logic [c_lw-1:0]            w_issued_inc;
    logic [c_lw-1:0]            w_sent_inc;
    logic                       w_fifo_empty;
    logic                       w_pop;
    logic                       w_pop_mem;
    logic                       w_push;
    logic [NEW_FEATURE_WIDTH-1:0] w_head;

    assign w_end        = {2'b00, word_idx_q} + {1'b0, len_q};
    assign w_credit_ok  = (count_q + c_cnt_w'(inflight_q)) <= c_credit_max;
    assign w_issued_inc = issued_q + c_lw'(1);
    assign w_sent_inc   = sent_q + c_lw'(w_pop);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        len_d       = len_q;
        issued_d    = issued_q;
        sent_d      = w_sent_inc;
        range_err_d = range_err_q;
        addrb_d     = addrb_q;
        w_issue     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    word_idx_d  = rd_base;
                    len_d       = rd_len;
                    issued_d    = '0;
                    sent_d      = '0;
                    range_err_d = 1'b0;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (len_q == '0) begin
                    state_d = S_FINISH;
                end else if (w_end > c_depth_ext) begin
                    range_err_d = 1'b1;
                    state_d     = S_FINISH;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Issue only while the FIFO can absorb every outstanding word.
                if (w_credit_ok) begin
                    w_issue    = 1'b1;
                    addrb_d    = {word_idx_q, 2'b00};
                    word_idx_d = word_idx_q + c_aw'(1);
                    issued_d   = w_issued_inc;
                    if (w_issued_inc == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_sent_inc == len_q) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output FIFO; a returning word bypasses straight to the head when empty
    // ------------------------------------------------------------------
    always_comb begin
        w_fifo_empty = (count_q == '0);
        m_tvalid     = !w_fifo_empty || inflight_q;
        w_head       = w_fifo_empty ? feat_bram_dout : mem_q[rd_ptr_q];
        m_tdata      = m_tvalid ? w_head : '0;
        m_tlast      = m_tvalid && (sent_q == (len_q - c_lw'(1)));
        w_pop        = m_tvalid && m_tready;
        w_pop_mem    = w_pop && !w_fifo_empty;
        w_push       = inflight_q && !(w_fifo_empty && w_pop);

        count_d  = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop_mem);
        wr_ptr_d = w_push    ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
        rd_ptr_d = w_pop_mem ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            word_idx_q  <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            sent_q      <= '0;
            range_err_q <= 1'b0;
            addrb_q     <= '0;
            inflight_q  <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            sent_q      <= sent_d;
            range_err_q <= range_err_d;
            addrb_q     <= addrb_d;
            inflight_q  <= w_issue;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= feat_bram_dout;
        end
    end

    assign busy            = (state_q == S_CHECK) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done            = (state_q == S_FINISH);
    assign range_err       = range_err_q;
    assign feat_bram_enb   = w_issue;
    assign feat_bram_addrb = w_issue ? {word_idx_q, 2'b00} : addrb_q;

endmodule
`default_nettype wire

// File: tb/tb_gat_feat_readback.sv
`default_nettype none
// ============================================================================
// Module      : tb_gat_feat_readback
// Description : Directed self-checking bench for gat_feat_readback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gat_feat_readback;

    localparam int c_aw = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [c_aw-1:0]   rd_base = '0;
    logic [c_aw:0]     rd_len = '0;
    logic              busy, done, range_err;
    logic [c_aw+1:0]   feat_bram_addrb;
    logic              feat_bram_enb;
    logic [31:0]       feat_bram_dout = '0;
    logic [31:0]       m_tdata;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic              m_tlast;

    gat_feat_readback dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .rd_base         (rd_base),
        .rd_len          (rd_len),
        .busy            (busy),
        .done            (done),
        .range_err       (range_err),
        .feat_bram_addrb (feat_bram_addrb),
        .feat_bram_enb   (feat_bram_enb),
        .feat_bram_dout  (feat_bram_dout),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tlast         (m_tlast)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input int w);
        logic [31:0] wv;
        wv = w;
        return {16'hFEA7, wv[15:0]};
    endfunction

    // BRAM: one-cycle read latency
    always @(posedge clk) begin
        if (feat_bram_enb) feat_bram_dout <= model(int'(feat_bram_addrb[c_aw+1:2]));
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0]     beats [$];
    bit              lasts [$];
    logic [c_aw+1:0] addrs [$];
    int enb_cnt, done_cnt, first_valid, done_cyc, last_beat_cyc, first_enb, last_enb;
    int out_cnt = 0;
    bit prev_stall = 0;
    logic [31:0] prev_data;
    bit prev_last;

    always @(negedge clk) begin
        if (rst) begin
            out_cnt    = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check_val("hold_valid", m_tvalid, 1);
                check_val("hold_data", m_tdata, prev_data);
                check_val("hold_last", m_tlast, prev_last);
            end
            if (feat_bram_enb) begin
                addrs.push_back(feat_bram_addrb);
                enb_cnt++;
                if (first_enb < 0) first_enb = cyc;
                last_enb = cyc;
                out_cnt++;
            end
            if (m_tvalid && m_tready) begin
                beats.push_back(m_tdata);
                lasts.push_back(m_tlast);
                last_beat_cyc = cyc;
                out_cnt--;
            end
            if (m_tvalid && first_valid < 0) first_valid = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) check_val("credit_le_4", out_cnt <= 4, 1);
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    function automatic bit ready_for(input int mode, input int k);
        bit [3:0] pat;
        pat = 4'b1001;
        if (mode == 0) return 1'b1;
        return pat[3 - (k % 4)];
    endfunction

    task automatic clear_log();
        beats.delete(); lasts.delete(); addrs.delete();
        enb_cnt = 0; done_cnt = 0; first_valid = -1; done_cyc = -1;
        last_beat_cyc = -1; first_enb = -1; last_enb = -1;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1
    task automatic do_req(input int base, input int len, input int mode, input bit exp_err,
                          input int dup_at, input bit start_in_fin);
        int  start_cyc, exp_beats, n_last;
        bit  seen;
        clear_log();
        rd_base   = base[c_aw-1:0];
        rd_len    = len[c_aw:0];
        start     = 1'b1;
        m_tready  = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 1; k < 400 && !seen; k++) begin
            if (k == 1) check_val("busy_in_check", busy, 1);
            m_tready = ready_for(mode, k);
            if (k == dup_at) begin
                start = 1'b1; rd_base = 16'd500; rd_len = 17'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            check_val("done_timeout", 0, 1);
        end else begin
            check_val("busy_at_done", busy, 0);
        end
        if (start_in_fin) begin
            start = 1'b1; rd_base = 16'd7; rd_len = 17'd5;
        end
        @(posedge clk); #1;
        start = 1'b0;

        exp_beats = (exp_err || len == 0) ? 0 : len;
        check_val("range_err", range_err, exp_err);
        check_val("done_count", done_cnt, 1);
        check_val("enb_count", enb_cnt, exp_beats);
        check_val("beat_count", beats.size(), exp_beats);
        n_last = 0;
        for (int i = 0; i < beats.size(); i++) begin
            check_val("beat_data", beats[i], model(base + i));
            if (lasts[i]) n_last++;
        end
        for (int i = 0; i < addrs.size(); i++) begin
            check_val("addrb", addrs[i], (base + i) * 4);
        end
        if (exp_beats > 0) begin
            check_val("tlast_count", n_last, 1);
            check_val("tlast_on_final", lasts[beats.size()-1], 1);
            check_val("done_after_last", done_cyc - last_beat_cyc, 1);
        end else begin
            check_val("no_valid", first_valid, -1);
            check_val("done_latency_empty", done_cyc - start_cyc, 2);
        end
        if (mode == 0 && exp_beats > 0) begin
            check_val("first_enb_latency", first_enb - start_cyc, 2);
            check_val("enb_contiguous", last_enb - first_enb, exp_beats - 1);
            check_val("first_valid_latency", first_valid - start_cyc, 3);
            check_val("done_latency", done_cyc - start_cyc, exp_beats + 3);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_range_err", range_err, 0);
        check_val("rst_enb", feat_bram_enb, 0);
        check_val("rst_addrb", feat_bram_addrb, 0);
        check_val("rst_tvalid", m_tvalid, 0);
        check_val("rst_tlast", m_tlast, 0);
        check_val("rst_tdata", m_tdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(0, 16, 0, 1'b0, -1, 1'b0);
        do_req(100, 8, 1, 1'b0, -1, 1'b0);
        do_req(5, 0, 0, 1'b0, -1, 1'b0);
        do_req(43320, 16, 0, 1'b1, -1, 1'b0);
        do_req(43312, 16, 0, 1'b0, -1, 1'b0);
        do_req(200, 32, 0, 1'b0, 5, 1'b1);
        do_req(300, 4, 0, 1'b0, -1, 1'b0);

        // Abort a 16-word request after 5 beats
        clear_log();
        rd_base = '0; rd_len = 17'd16; start = 1'b1; m_tready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (beats.size() < 5 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("abort_reached_5", beats.size() >= 5, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_enb", feat_bram_enb, 0);
        check_val("abort_addrb", feat_bram_addrb, 0);
        check_val("abort_tvalid", m_tvalid, 0);
        check_val("abort_tlast", m_tlast, 0);
        check_val("abort_tdata", m_tdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        do_req(0, 4, 0, 1'b0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
